// File: rtl/truth_table_sweeper.sv
// truth_table_sweeper
//   Steps a 4-input gate netlist through all 16 input vectors, holds each
//   vector SETTLE+1 cycles, samples the single-bit response on the last edge
//   of the hold and assembles a 16-bit truth-table code (vector k -> tt[15-k]).
//   At sweep end the code is compared with a golden value.
//
// Ports
//   clk       clock, rising edge
//   rst_n     asynchronous active-low reset
//   start     begin a sweep (accepted only in IDLE, and not together with abort)
//   abort     cancel a sweep in progress
//   expected  golden truth-table code, sampled on the final sample edge
//   dut_out   response of the gate under characterization
//   stim      stimulus vector (stim[3] -> input _0 ... stim[0] -> input _3)
//   tt        captured truth-table code
//   busy      sweep in progress
//   done      one-cycle completion pulse
//   valid     tt holds a complete, un-aborted result
//   match     tt == expected (meaningful while valid)
module truth_table_sweeper #(
    parameter int SETTLE = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        abort,
    input  logic [15:0] expected,
    input  logic        dut_out,
    output logic [3:0]  stim,
    output logic [15:0] tt,
    output logic        busy,
    output logic        done,
    output logic        valid,
    output logic        match
);

    localparam logic [3:0] SETTLE_C = 4'(SETTLE);

    typedef enum logic [1:0] {S_IDLE, S_DRIVE, S_DONE} state_t;

    state_t      state, state_next;
    logic [3:0]  k;
    logic [3:0]  cnt;
    logic        sample;
    logic        last;
    logic [15:0] tt_sampled;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_next;
    end

    // tt_sampled is tt with the current response merged in, so the final
    // compare sees all 16 bits on the same edge that bit 0 is captured.
    always_comb begin
        state_next = state;
        sample     = 1'b0;
        last       = 1'b0;
        tt_sampled = tt;
        tt_sampled[4'd15 - k] = dut_out;
        case (state)
            S_IDLE:  if (start && !abort) state_next = S_DRIVE;
            S_DRIVE: begin
                // abort wins over a coincident sample
                if (abort) begin
                    state_next = S_IDLE;
                end else if (cnt == SETTLE_C) begin
                    sample = 1'b1;
                    if (k == 4'd15) begin
                        last       = 1'b1;
                        state_next = S_DONE;
                    end
                end
            end
            S_DONE:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            k     <= 4'd0;
            cnt   <= 4'd0;
            stim  <= 4'h0;
            tt    <= 16'h0000;
            busy  <= 1'b0;
            done  <= 1'b0;
            valid <= 1'b0;
            match <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    done <= 1'b0;
                    if (start && !abort) begin
                        k     <= 4'd0;
                        cnt   <= 4'd0;
                        stim  <= 4'h0;
                        tt    <= 16'h0000;
                        busy  <= 1'b1;
                        valid <= 1'b0;
                        match <= 1'b0;
                    end
                end
                S_DRIVE: begin
                    if (abort) begin
                        k     <= 4'd0;
                        cnt   <= 4'd0;
                        stim  <= 4'h0;
                        busy  <= 1'b0;
                        valid <= 1'b0;
                    end else if (sample) begin
                        tt  <= tt_sampled;
                        cnt <= 4'd0;
                        if (last) begin
                            stim  <= 4'h0;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            valid <= 1'b1;
                            match <= (tt_sampled == expected);
                        end else begin
                            k    <= k + 4'd1;
                            stim <= k + 4'd1;
                        end
                    end else begin
                        cnt <= cnt + 4'd1;
                    end
                end
                S_DONE: begin
                    done <= 1'b0;
                end
                default: begin
                    done <= 1'b0;
                    busy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Testbench for truth_table_sweeper: instance a uses SETTLE=2, instance b
// SETTLE=0. Each instance sees a behavioural gate whose truth-table code is
// held in gold_a / gold_b (output for vector v is code bit 15-v).
module tb_truth_table_sweeper;

    localparam int SA = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start_a, abort_a, dut_out_a;
    logic        start_b, abort_b, dut_out_b;
    logic [15:0] exp_a, exp_b, gold_a, gold_b;
    logic [3:0]  stim_a, stim_b;
    logic [15:0] tt_a, tt_b;
    logic        busy_a, done_a, valid_a, match_a;
    logic        busy_b, done_b, valid_b, match_b;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    assign dut_out_a = gold_a[4'd15 - stim_a];
    assign dut_out_b = gold_b[4'd15 - stim_b];

    truth_table_sweeper #(.SETTLE(SA)) dut_a (
        .clk(clk), .rst_n(rst_n), .start(start_a), .abort(abort_a),
        .expected(exp_a), .dut_out(dut_out_a), .stim(stim_a), .tt(tt_a),
        .busy(busy_a), .done(done_a), .valid(valid_a), .match(match_a));

    truth_table_sweeper #(.SETTLE(0)) dut_b (
        .clk(clk), .rst_n(rst_n), .start(start_b), .abort(abort_b),
        .expected(exp_b), .dut_out(dut_out_b), .stim(stim_b), .tt(tt_b),
        .busy(busy_b), .done(done_b), .valid(valid_b), .match(match_b));

    // One sweep on instance a, entered and left on a negedge.
    // abort_cyc < 0: run to completion; otherwise abort is raised during busy
    // cycle abort_cyc. poke_done re-raises start during the DONE cycle.
    task automatic sweep_a(input logic [15:0] code, input logic [15:0] expv,
                           input int abort_cyc, input bit poke_done);
        int cyc, dcnt, serr, nvec, want_cyc;
        logic [15:0] ones, want_tt;
        gold_a = code;
        exp_a  = expv;
        ones   = '1;
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        total++;
        if (busy_a !== 1'b1 || valid_a !== 1'b0 || tt_a !== 16'h0000) begin
            bad++;
            $display("FAIL sweep_start busy=%b valid=%b tt=%h want busy=1 valid=0 tt=0000", busy_a, valid_a, tt_a);
        end
        cyc = 0; dcnt = 0; serr = 0;
        while (busy_a === 1'b1 && cyc < 200) begin
            if (stim_a !== 4'(cyc / (SA + 1))) serr++;
            if (done_a !== 1'b0) dcnt++;
            if (cyc == abort_cyc) abort_a = 1'b1;
            @(negedge clk);
            abort_a = 1'b0;
            cyc++;
        end
        if (abort_cyc < 0) begin
            nvec = 16; want_cyc = 16 * (SA + 1);
        end else begin
            nvec = abort_cyc / (SA + 1); want_cyc = abort_cyc + 1;
        end
        want_tt = (nvec >= 16) ? code : (code & ~(ones >> nvec));
        total++;
        if (cyc != want_cyc) begin
            bad++;
            $display("FAIL busy_len got=%0d want=%0d", cyc, want_cyc);
        end
        total++;
        if (serr != 0 || dcnt != 0) begin
            bad++;
            $display("FAIL stim_seq stim_errs=%0d early_done=%0d want 0/0", serr, dcnt);
        end
        total++;
        if (tt_a !== want_tt || stim_a !== 4'h0) begin
            bad++;
            $display("FAIL tt_end tt=%h stim=%h want tt=%h stim=0", tt_a, stim_a, want_tt);
        end
        total++;
        if (done_a !== (abort_cyc < 0) || valid_a !== (abort_cyc < 0)) begin
            bad++;
            $display("FAIL done_valid done=%b valid=%b want=%b", done_a, valid_a, abort_cyc < 0);
        end
        if (abort_cyc < 0) begin
            total++;
            if (match_a !== (code == expv)) begin
                bad++;
                $display("FAIL match got=%b want=%b code=%h exp=%h", match_a, code == expv, code, expv);
            end
        end
        if (poke_done) start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        total++;
        if (done_a !== 1'b0 || busy_a !== 1'b0 || valid_a !== (abort_cyc < 0) || tt_a !== want_tt) begin
            bad++;
            $display("FAIL after_end done=%b busy=%b valid=%b tt=%h want 0/0/%b/%h",
                     done_a, busy_a, valid_a, tt_a, abort_cyc < 0, want_tt);
        end
    endtask

    task automatic test_reset();
        total++;
        if ({stim_a, tt_a, busy_a, done_a, valid_a, match_a} !== 24'h0 ||
            {stim_b, tt_b, busy_b, done_b, valid_b, match_b} !== 24'h0) begin
            bad++;
            $display("FAIL reset_state a=%h/%h b=%h/%h want all zero", stim_a, tt_a, stim_b, tt_b);
        end
    endtask

    task automatic test_golden();
        sweep_a(16'h2FC7, 16'h2FC7, -1, 1'b0);
        sweep_a(16'h2FC7, 16'h2FC6, -1, 1'b0);
    endtask

    task automatic test_random();
        logic [15:0] c;
        for (int i = 0; i < 4; i++) begin
            c = 16'($urandom);
            sweep_a(c, (i % 2 == 0) ? c : 16'($urandom), -1, 1'b0);
        end
    endtask

    task automatic test_settle0();
        int cyc, serr, dcnt;
        logic [15:0] codes [2];
        codes[0] = 16'hFFFF;
        codes[1] = 16'($urandom);
        for (int r = 0; r < 2; r++) begin
            gold_b = codes[r];
            exp_b  = codes[r];
            start_b = 1'b1;
            @(negedge clk);
            start_b = 1'b0;
            cyc = 0; serr = 0; dcnt = 0;
            while (busy_b === 1'b1 && cyc < 100) begin
                if (stim_b !== 4'(cyc)) serr++;
                if (done_b !== 1'b0) dcnt++;
                @(negedge clk);
                cyc++;
            end
            total++;
            if (cyc != 16 || serr != 0 || dcnt != 0) begin
                bad++;
                $display("FAIL s0_seq busy=%0d stim_errs=%0d early_done=%0d want 16/0/0", cyc, serr, dcnt);
            end
            total++;
            if (tt_b !== codes[r] || done_b !== 1'b1 || match_b !== 1'b1 || valid_b !== 1'b1) begin
                bad++;
                $display("FAIL s0_end tt=%h done=%b match=%b valid=%b want tt=%h 1/1/1", tt_b, done_b, match_b, valid_b, codes[r]);
            end
            @(negedge clk);
            total++;
            if (done_b !== 1'b0) begin
                bad++;
                $display("FAIL s0_pulse done=%b want 0", done_b);
            end
        end
    endtask

    task automatic test_abort();
        sweep_a(16'h2FC7, 16'h2FC7, 5 * (SA + 1), 1'b0);
        for (int i = 0; i < 3; i++)
            sweep_a(16'($urandom), 16'h0, int'($urandom_range(0, 15)) * (SA + 1) + int'($urandom_range(0, SA)), 1'b0);
        // abort on the very last sample cycle must win over completion
        sweep_a(16'hFFFF, 16'hFFFF, 16 * (SA + 1) - 1, 1'b0);
    endtask

    task automatic test_idle_controls();
        logic [15:0] t0;
        logic        v0;
        sweep_a(16'hA5C3, 16'hA5C3, -1, 1'b0);
        t0 = tt_a; v0 = valid_a;
        start_a = 1'b1; abort_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0; abort_a = 1'b0;
        @(negedge clk);
        total++;
        if (busy_a !== 1'b0 || valid_a !== v0 || tt_a !== t0) begin
            bad++;
            $display("FAIL start_abort_idle busy=%b valid=%b tt=%h want 0/%b/%h", busy_a, valid_a, tt_a, v0, t0);
        end
        abort_a = 1'b1;
        @(negedge clk);
        abort_a = 1'b0;
        total++;
        if (valid_a !== 1'b1 || match_a !== 1'b1 || tt_a !== 16'hA5C3) begin
            bad++;
            $display("FAIL abort_idle valid=%b match=%b tt=%h want 1/1/a5c3", valid_a, match_a, tt_a);
        end
    endtask

    task automatic test_back_to_back();
        // start during DONE is dropped; sweep_a checks busy stays low after it
        sweep_a(16'h1234, 16'h1234, -1, 1'b1);
        sweep_a(16'h2FC7, 16'h2FC7, -1, 1'b0);
    endtask

    task automatic test_restart_reset();
        gold_a = 16'h2FC7;
        exp_a  = 16'h2FC7;
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        for (int c = 0; c < 20; c++) begin
            if (c == 4) start_a = 1'b1;
            @(negedge clk);
            start_a = 1'b0;
        end
        total++;
        if (busy_a !== 1'b1 || stim_a !== 4'(20 / (SA + 1))) begin
            bad++;
            $display("FAIL no_restart busy=%b stim=%h want 1/%h", busy_a, stim_a, 4'(20 / (SA + 1)));
        end
        #2 rst_n = 1'b0;
        #1;
        total++;
        if ({stim_a, tt_a, busy_a, done_a, valid_a, match_a} !== 24'h0) begin
            bad++;
            $display("FAIL reset_mid stim=%h tt=%h busy=%b done=%b valid=%b match=%b want all 0",
                     stim_a, tt_a, busy_a, done_a, valid_a, match_a);
        end
        @(negedge clk);
        rst_n = 1'b1;
        sweep_a(16'h2FC7, 16'h2FC7, -1, 1'b0);
    endtask

    initial begin
        rst_n = 1'b1;
        start_a = 1'b0; abort_a = 1'b0; start_b = 1'b0; abort_b = 1'b0;
        exp_a = '0; exp_b = '0; gold_a = '0; gold_b = '0;
        #1 rst_n = 1'b0;
        #2;
        test_reset();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        test_golden();
        test_random();
        test_settle0();
        test_abort();
        test_idle_controls();
        test_back_to_back();
        test_restart_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
